// File: rtl/bme280_sequencer_if.sv
// bme280_sequencer_if: sequencer <-> wrapper/host signal bundle.
// master = sequencer side, slave = wrapper and host side.
interface bme280_sequencer_if;
  logic [3:0]  register_selector;
  logic [7:0]  data;
  logic        start;
  logic        continuous;
  logic        busy;
  logic        meas_valid;
  logic [19:0] raw_press;
  logic [19:0] raw_temp;
  logic [15:0] raw_hum;
  logic [7:0]  chip_id;
  logic        id_error;

  modport master (
    input  data, start, continuous,
    output register_selector, busy, meas_valid,
    output raw_press, raw_temp, raw_hum,
    output chip_id, id_error
  );

  modport slave (
    output data, start, continuous,
    input  register_selector, busy, meas_valid,
    input  raw_press, raw_temp, raw_hum,
    input  chip_id, id_error
  );
endinterface

// File: rtl/bme280_sequencer.sv
// bme280_sequencer: timed BME280 selector sequence and raw burst capture.
// Chip-ID check stage is built only when BME280_ID_CHECK_EN is defined.
module bme280_sequencer #(
  parameter int         TRANSACTION_CYCLES = 200000,
  parameter int         GAP_CYCLES         = 1000,
  parameter int         RESET_WAIT_CYCLES  = 200000,
  parameter int         POLL_CYCLES        = 10000000,
  parameter logic [7:0] EXPECTED_ID        = 8'h60
) (
  input logic                clk,
  input logic                rst,
  bme280_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, READ_ID, WRITE_RESET, RESET_WAIT,
    WRITE_CTRL, POLL_WAIT, BURST, DONE
  } state_t;

  localparam logic [31:0] T_LAST = 32'(TRANSACTION_CYCLES - 1);
  localparam logic [31:0] G_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] W_LAST = 32'(RESET_WAIT_CYCLES - 1);
  localparam logic [31:0] P_LAST = 32'(POLL_CYCLES - 1);

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic        gap, gap_n;
  logic [2:0]  idx, idx_n;
  logic [3:0]  sel;
  logic        cap_byte, load_raw;
  logic [55:0] shadow;
  logic [19:0] press_q, temp_q;
  logic [15:0] hum_q;
  logic        valid_q;
`ifdef BME280_ID_CHECK_EN
  logic        cap_id, clr_err;
  logic [7:0]  chip_id_q;
  logic        id_error_q;
`endif

  // state, dwell counter, gap phase and burst index
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      gap   <= 1'b0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      gap   <= gap_n;
      idx   <= idx_n;
    end
  end

  // next state, selector code and capture strobes
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 32'd1;
    gap_n    = gap;
    idx_n    = idx;
    sel      = 4'b0000;
    cap_byte = 1'b0;
    load_raw = 1'b0;
`ifdef BME280_ID_CHECK_EN
    cap_id   = 1'b0;
    clr_err  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.start) begin
          gap_n = 1'b0;
          idx_n = '0;
`ifdef BME280_ID_CHECK_EN
          clr_err = 1'b1;
          state_n = READ_ID;
`else
          state_n = WRITE_RESET;
`endif
        end
      end
      READ_ID, WRITE_RESET, WRITE_CTRL, BURST: begin
        if (!gap) begin
          unique case (1'b1)
            state == READ_ID:     sel = 4'b0001;
            state == WRITE_RESET: sel = 4'b0111;
            state == WRITE_CTRL:  sel = 4'b0101;
            default:              sel = {1'b1, idx};
          endcase
          if (cnt == T_LAST) begin
            cnt_n = '0;
            gap_n = 1'b1;
            if (state == BURST) begin
              cap_byte = 1'b1;
              if (idx == 3'd7) begin
                state_n  = DONE;
                gap_n    = 1'b0;
                load_raw = 1'b1;
              end
            end
`ifdef BME280_ID_CHECK_EN
            if (state == READ_ID) begin
              cap_id = 1'b1;
              if (bus.data != EXPECTED_ID) begin
                state_n = IDLE;
                gap_n   = 1'b0;
              end
            end
`endif
          end
        end else if (cnt == G_LAST) begin
          cnt_n = '0;
          gap_n = 1'b0;
          unique case (1'b1)
            state == READ_ID:     state_n = WRITE_RESET;
            state == WRITE_RESET: state_n = RESET_WAIT;
            state == WRITE_CTRL:  state_n = POLL_WAIT;
            default:              idx_n = idx + 3'd1;
          endcase
        end
      end
      RESET_WAIT: begin
        if (cnt == W_LAST) begin
          cnt_n   = '0;
          state_n = WRITE_CTRL;
        end
      end
      POLL_WAIT: begin
        if (cnt == P_LAST) begin
          cnt_n   = '0;
          gap_n   = 1'b0;
          idx_n   = '0;
          state_n = BURST;
        end
      end
      DONE: begin
        if (cnt == G_LAST) begin
          cnt_n   = '0;
          state_n = bus.continuous ? POLL_WAIT : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // burst shadow bytes and published raw words
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      press_q <= '0;
      temp_q  <= '0;
      hum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= load_raw;
      if (cap_byte)
        shadow <= {shadow[47:0], bus.data};
      if (load_raw) begin
        press_q <= {shadow[55:40], shadow[39:36]};
        temp_q  <= {shadow[31:16], shadow[15:12]};
        hum_q   <= {shadow[7:0], bus.data};
      end
    end
  end

`ifdef BME280_ID_CHECK_EN
  // chip ID capture and sticky mismatch flag
  always_ff @(posedge clk) begin
    if (rst) begin
      chip_id_q  <= '0;
      id_error_q <= 1'b0;
    end else begin
      if (clr_err)
        id_error_q <= 1'b0;
      if (cap_id) begin
        chip_id_q <= bus.data;
        if (bus.data != EXPECTED_ID)
          id_error_q <= 1'b1;
      end
    end
  end

  assign bus.chip_id  = chip_id_q;
  assign bus.id_error = id_error_q;
`else
  assign bus.chip_id  = '0;
  assign bus.id_error = 1'b0;
`endif

  assign bus.register_selector = sel;
  assign bus.busy              = (state != IDLE);
  assign bus.meas_valid        = valid_q;
  assign bus.raw_press         = press_q;
  assign bus.raw_temp          = temp_q;
  assign bus.raw_hum           = hum_q;
endmodule

// File: tb/tb_bme280_sequencer.sv
// tb_bme280_sequencer: scenario table plus meas_valid scoreboard.
// Wrapper model answers the selector with ID and fixed burst bytes.
module tb_bme280_sequencer;
  localparam int T = 16;
  localparam int G = 4;
  localparam int W = 32;
  localparam int P = 64;
`ifdef BME280_ID_CHECK_EN
  localparam bit IDC = 1'b1;
`else
  localparam bit IDC = 1'b0;
`endif
  localparam int LAT = IDC ? 313 : 293;
  localparam int B0  = IDC ? 157 : 137;
  localparam int PER = 224;

  typedef struct {
    string      nm;
    bit         do_reset;
    logic [7:0] id;
    bit         id_ok;
    bit         cont;
    bit         spam;
    int         abort_at;
    int         ncyc;
    logic [7:0] exp_chip;
    bit         exp_err;
  } scn_t;

  typedef struct {
    int          cyc;
    logic [19:0] press;
    logic [19:0] temp;
    logic [15:0] hum;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] id_byte;
  logic [7:0] burst_b [8];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  exp_t sb[$];
  scn_t tbl[$];

  bme280_sequencer_if bus();

  bme280_sequencer #(
    .TRANSACTION_CYCLES(T),
    .GAP_CYCLES(G),
    .RESET_WAIT_CYCLES(W),
    .POLL_CYCLES(P),
    .EXPECTED_ID(8'h60)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.data = 8'h00;
    if (bus.register_selector == 4'b0001)
      bus.data = id_byte;
    else if (bus.register_selector[3])
      bus.data = burst_b[bus.register_selector[2:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_sel(int c, bit id_ok, bit cont);
    int t;
    if (c < 1) return 4'b0000;
    t = c - 1;
    if (IDC) begin
      if (t < T) return 4'b0001;
      if (!id_ok || t < T + G) return 4'b0000;
      t = t - (T + G);
    end
    if (t < T) return 4'b0111;
    if (t < T + G + W) return 4'b0000;
    t = t - (T + G + W);
    if (t < T) return 4'b0101;
    if (t < T + G + P) return 4'b0000;
    t = t - (T + G + P);
    if (cont) t = t % PER;
    if (t >= 8 * (T + G)) return 4'b0000;
    if (t % (T + G) < T) return 4'(8 + t / (T + G));
    return 4'b0000;
  endfunction

  function automatic bit exp_busy(int c, bit id_ok, bit cont);
    if (c < 1) return 1'b0;
    if (IDC && !id_ok) return c <= T;
    if (cont) return 1'b1;
    return c <= LAT + G - 1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_sel"}, 32'(bus.register_selector), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_valid"}, 32'(bus.meas_valid), 0);
    chk({tag, "_press"}, 32'(bus.raw_press), 0);
    chk({tag, "_temp"}, 32'(bus.raw_temp), 0);
    chk({tag, "_hum"}, 32'(bus.raw_hum), 0);
    chk({tag, "_chip"}, 32'(bus.chip_id), 0);
    chk({tag, "_err"}, 32'(bus.id_error), 0);
  endtask

  task automatic run_scn(input scn_t s);
    exp_t e;
    bus.start = 1'b0;
    bus.continuous = 1'b0;
    if (s.do_reset) begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cyc = 0;
      chk_zero({s.nm, "_rst"});
      rst = 1'b0;
    end
    id_byte = s.id;
    burst_b = '{8'hAB, 8'hCD, 8'hE5, 8'h81,
                8'h23, 8'h47, 8'h5A, 8'h6B};
    if (s.id_ok)
      sb.push_back('{LAT, 20'hABCDE, 20'h81234, 16'h5A6B});
    if (s.cont)
      sb.push_back('{LAT + PER, 20'hABCD3, 20'h81234, 16'h5A6B});
    bus.continuous = s.cont;
    bus.start = 1'b1;
    cyc = 0;
    for (int i = 0; i < s.ncyc; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.start = 1'b0;
      if (s.abort_at != 0 && cyc == s.abort_at + 1) begin
        chk_zero({s.nm, "_abort"});
        chk({s.nm, "_sb_drained"}, 32'(sb.size()), 0);
        rst = 1'b0;
        sb.delete();
        bus.continuous = 1'b0;
        return;
      end
      chk({s.nm, "_sel"}, 32'(bus.register_selector),
          32'(exp_sel(cyc, s.id_ok, s.cont)));
      chk({s.nm, "_busy"}, 32'(bus.busy),
          32'(exp_busy(cyc, s.id_ok, s.cont)));
      if (cyc == 1)
        chk({s.nm, "_err_cleared"}, 32'(bus.id_error), 0);
      if (bus.meas_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL %s_valid: pulse at cycle %0d, expected none",
                   s.nm, cyc);
        end else begin
          e = sb.pop_front();
          chk({s.nm, "_valid_cycle"}, 32'(cyc), 32'(e.cyc));
          chk({s.nm, "_press"}, 32'(bus.raw_press), 32'(e.press));
          chk({s.nm, "_temp"}, 32'(bus.raw_temp), 32'(e.temp));
          chk({s.nm, "_hum"}, 32'(bus.raw_hum), 32'(e.hum));
        end
      end
      if (s.cont && cyc == LAT)
        burst_b[2] = 8'h3F;
      if (s.cont && cyc == LAT + 100) begin
        chk({s.nm, "_hold_press"}, 32'(bus.raw_press), 32'h000ABCDE);
        chk({s.nm, "_hold_valid"}, 32'(bus.meas_valid), 0);
      end
      if (s.abort_at != 0 && cyc == s.abort_at)
        rst = 1'b1;
      if (s.spam && (cyc == 5 || cyc == 100 || cyc == LAT - 10))
        bus.start = 1'b1;
    end
    bus.start = 1'b0;
    bus.continuous = 1'b0;
    chk({s.nm, "_sb_empty"}, 32'(sb.size()), 0);
    chk({s.nm, "_chip_id"}, 32'(bus.chip_id), 32'(s.exp_chip));
    chk({s.nm, "_id_error"}, 32'(bus.id_error), 32'(s.exp_err));
    sb.delete();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.continuous = 1'b0;
    id_byte = 8'h00;
    burst_b = '{default: 8'h00};
    tbl.push_back('{"single", 1'b1, 8'h60, 1'b1, 1'b0, 1'b0, 0,
                    LAT + G + 8, IDC ? 8'h60 : 8'h00, 1'b0});
`ifdef BME280_ID_CHECK_EN
    tbl.push_back('{"id_bad", 1'b1, 8'h58, 1'b0, 1'b0, 1'b0, 0,
                    40, 8'h58, 1'b1});
    tbl.push_back('{"id_retry", 1'b0, 8'h60, 1'b1, 1'b0, 1'b0, 0,
                    LAT + G + 8, 8'h60, 1'b0});
`endif
    tbl.push_back('{"cont", 1'b1, 8'h60, 1'b1, 1'b1, 1'b0,
                    B0 + 2 * PER + 3 * (T + G) + 5, 2000,
                    IDC ? 8'h60 : 8'h00, 1'b0});
    tbl.push_back('{"spam", 1'b0, 8'h60, 1'b1, 1'b0, 1'b1, 0,
                    LAT + G + 8, IDC ? 8'h60 : 8'h00, 1'b0});
    foreach (tbl[k])
      run_scn(tbl[k]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bme280_sequencer.md
Name: bme280_sequencer

Overview:
- Autonomous measurement sequencer that sits directly upstream of the BME280 register-access wrapper.
- Generates the 4-bit register_selector code sequence and samples the returned 8-bit data bus.
- Runs chip-ID check, soft reset, normal-mode configuration, then burst-reads all eight raw measurement bytes and assembles them into raw pressure/temperature/humidity words.
- The I2C engine has no done flag, so every transaction is timed by a fixed dwell counter followed by a disable gap that re-arms the engine.

Parameters:
- TRANSACTION_CYCLES, 200000: cycles a selector code is held per I2C transaction (must cover one full transfer); minimum 2.
- GAP_CYCLES, 1000: cycles selector is held at DISABLE (0000) after each transaction; minimum 1.
- RESET_WAIT_CYCLES, 200000: DISABLE cycles after soft reset before configuration.
- POLL_CYCLES, 10000000: DISABLE cycles before each measurement burst.
- EXPECTED_ID, 8'h60: required chip ID.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin sequence; sampled only in IDLE
- continuous  in  1  1: repeat bursts until rst; 0: single burst then IDLE
- register_selector  out  4  selector code to wrapper
- data  in  8  byte returned by wrapper
- busy  out  1  high whenever not in IDLE
- meas_valid  out  1  one-cycle pulse, raw outputs updated
- raw_press  out  20  {F7, F8, F9[7:4]}
- raw_temp  out  20  {FA, FB, FC[7:4]}
- raw_hum  out  16  {FD, FE}
- chip_id  out  8  last captured ID byte
- id_error  out  1  sticky, set on ID mismatch

Behaviour:
- Reset: register_selector=0000, busy=0, meas_valid=0, raw_press/raw_temp/raw_hum=0, chip_id=0, id_error=0, all counters cleared, state IDLE.
- Reset mid-operation aborts immediately; selector returns to 0000 in the cycle after rst is sampled.
- States: IDLE, READ_ID, WRITE_RESET, RESET_WAIT, WRITE_CTRL, POLL_WAIT, BURST, DONE.
- Each transaction: selector = code for exactly TRANSACTION_CYCLES cycles, then 0000 for GAP_CYCLES cycles.
- data is sampled on the last dwell cycle (dwell counter == TRANSACTION_CYCLES-1).
- IDLE -> READ_ID when start=1.
  - start clears id_error.
  - start is ignored while busy.
  - Selector changes to the first code on the cycle after start is sampled.
- READ_ID (0001): capture chip_id.
  - Mismatch vs EXPECTED_ID: set id_error, skip the gap, return to IDLE next cycle with selector 0000.
  - Match: go to WRITE_RESET.
- WRITE_RESET (0111) -> RESET_WAIT (0000 for RESET_WAIT_CYCLES; no extra gap) -> WRITE_CTRL (0101) -> POLL_WAIT (0000 for POLL_CYCLES) -> BURST.
- BURST issues codes 1000,1001,1010,1011,1100,1101,1110,1111 in order.
  - Each byte is captured into an internal shadow register.
  - Outputs are not touched mid-burst.
- DONE: entered on the cycle after the final byte's sample cycle, in place of that read's first gap cycle.
  - All three raw outputs update together and meas_valid pulses for that one cycle.
  - The remaining GAP_CYCLES-1 gap cycles follow.
  - Then go to POLL_WAIT if continuous=1, else IDLE. continuous is sampled at the end of that gap.
- XLSB bytes: only bits [7:4] are used; bits [3:0] are discarded.
- Latency: meas_valid asserts at cycle 1 + 3(T+G) + W + P + 7(T+G) + T after the start-sample cycle (T=TRANSACTION_CYCLES, G=GAP_CYCLES, W=RESET_WAIT_CYCLES, P=POLL_CYCLES).
- Continuous mode: successive meas_valid pulses are P + 8(T+G) cycles apart.
- busy=1 from the cycle after start is sampled until IDLE is re-entered.

Optional Feature:
- Macro BME280_ID_CHECK_EN.
- Defined: READ_ID state present, behaviour as above.
- Undefined:
  - READ_ID is removed; IDLE -> WRITE_RESET directly.
  - chip_id and id_error are tied to 0.
  - Latency is reduced by T+G.

Test Plan:
- Params T=16, G=4, W=32, P=64, ID check enabled, continuous=0. Bench wrapper model returns 8'h60 for the ID read, and 0xAB,0xCD,0xE5,0x81,0x23,0x47,0x5A,0x6B for the burst. Pulse start -> selector sequence 0001,0111,0101,1000..1111, each held 16 cycles with 4-cycle gaps. meas_valid pulses once at cycle 313. raw_press=20'hABCDE, raw_temp=20'h81234, raw_hum=16'h5A6B, chip_id=8'h60. Back to IDLE, busy=0.
- Same setup, ID model returns 8'h58 -> chip_id=8'h58, id_error=1. Selector 0000 from cycle 17 onward, no meas_valid, busy=0. A second start clears id_error.
- continuous=1 -> second meas_valid exactly 224 cycles after the first. A new XLSB value appears only in the second pulse; outputs are stable between pulses.
- Assert rst during BURST (4th byte) -> next cycle selector=0000, all outputs zero, busy=0. A subsequent start replays the full sequence from READ_ID.
- Pulse start while busy=1 -> no effect on sequence timing; compare against the scenario-1 trace.
- BME280_ID_CHECK_EN undefined -> first code 0111, meas_valid at cycle 293, chip_id=0, id_error=0.
